// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings and FSM state type for the pipeline hazard controller
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_MA = 2'b01,
        FWD_WB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - operand forwarding select for one source register
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_ma_rd,
    input  logic       i_ma_regwen,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_regwen,
    output fwd_sel_t   o_sel
);

    logic w_ma_hit;
    logic w_wb_hit;

    assign w_ma_hit = i_ma_regwen && (i_ma_rd == i_rs) && (i_ma_rd != 5'd0);
    assign w_wb_hit = i_wb_regwen && (i_wb_rd == i_rs) && (i_wb_rd != 5'd0);

    // The younger EX/MA result wins over the older MA/WB value.
    always_comb begin
        o_sel = FWD_RF;
        if (w_ma_hit) begin
            o_sel = FWD_MA;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forward control with memory-wait timeout
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_RegWEn,
    input  logic [1:0]  ex_WBSel,
    input  logic [4:0]  ma_rd,
    input  logic        ma_RegWEn,
    input  logic        ma_mem_access,
    input  logic [4:0]  wb_rd,
    input  logic        wb_RegWEn,
    input  logic        ex_branch_taken,
    input  logic        dmem_ready,
    input  logic [4:0]  if_rs1,
    input  logic [4:0]  if_rs2,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_ma,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        bubble_ma_wb,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_timeout,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [7:0] LP_WAIT_MAX = WAIT_MAX[7:0];

    hz_state_t   r_state;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    fwd_sel_t w_sel_a;
    fwd_sel_t w_sel_b;
    logic     w_timeout;
    logic     w_freeze;
    logic     w_load_use;
    logic     w_branch_flush;

    fwd_unit u_fwd_a (
        .i_rs        (id_rs1),
        .i_ma_rd     (ma_rd),
        .i_ma_regwen (ma_RegWEn),
        .i_wb_rd     (wb_rd),
        .i_wb_regwen (wb_RegWEn),
        .o_sel       (w_sel_a)
    );

    fwd_unit u_fwd_b (
        .i_rs        (id_rs2),
        .i_ma_rd     (ma_rd),
        .i_ma_regwen (ma_RegWEn),
        .i_wb_rd     (wb_rd),
        .i_wb_regwen (wb_RegWEn),
        .o_sel       (w_sel_b)
    );

    assign w_timeout  = (r_state == ST_TIMEOUT);
    assign w_freeze   = ma_mem_access && !dmem_ready && !w_timeout;
    assign w_load_use = ex_RegWEn && (ex_WBSel == WB_MEM) && (ex_rd != 5'd0) &&
                        ((ex_rd == if_rs1) || (ex_rd == if_rs2));

    // Priority: reset, timeout, memory freeze, branch flush, load-use.
    always_comb begin
        stall_pc       = 1'b0;
        stall_if_id    = 1'b0;
        stall_id_ex    = 1'b0;
        stall_ex_ma    = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        bubble_ma_wb   = 1'b0;
        w_branch_flush = 1'b0;
        if (!reset) begin
            if (w_timeout || w_freeze) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                stall_id_ex  = 1'b1;
                stall_ex_ma  = 1'b1;
                bubble_ma_wb = 1'b1;
            end else if (ex_branch_taken) begin
                flush_if_id    = 1'b1;
                flush_id_ex    = 1'b1;
                w_branch_flush = 1'b1;
            end else if (w_load_use) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
        end
    end

    assign fwd_a       = (reset || w_timeout) ? FWD_RF : w_sel_a;
    assign fwd_b       = (reset || w_timeout) ? FWD_RF : w_sel_b;
    assign mem_timeout = w_timeout;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 8'd0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (stall_pc && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_branch_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_freeze) begin
                        r_state    <= ST_MEM_WAIT;
                        r_wait_cnt <= 8'd0;
                    end
                end
                ST_MEM_WAIT: begin
                    // A withdrawn access also ends the wait; only a live, unanswered one times out.
                    if (dmem_ready || !ma_mem_access) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt == LP_WAIT_MAX) begin
                        r_state <= ST_TIMEOUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_TIMEOUT: begin
                    r_state <= ST_TIMEOUT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd, ma_rd, wb_rd, if_rs1, if_rs2;
    logic        ex_RegWEn, ma_RegWEn, wb_RegWEn, ma_mem_access, ex_branch_taken, dmem_ready;
    logic [1:0]  ex_WBSel;
    logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_ma;
    logic        flush_if_id, flush_id_ex, bubble_ma_wb;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_timeout;
    logic [15:0] stall_count, flush_count;

    always #5 clk = ~clk;

    hazard_ctrl #(.WAIT_MAX(255)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn), .ex_WBSel(ex_WBSel),
        .ma_rd(ma_rd), .ma_RegWEn(ma_RegWEn), .ma_mem_access(ma_mem_access),
        .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn),
        .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
        .if_rs1(if_rs1), .if_rs2(if_rs2),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_ma(stall_ex_ma),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .bubble_ma_wb(bubble_ma_wb),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_ma, flush_if_id, flush_id_ex, bubble_ma_wb}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b1111001;
    localparam logic [6:0] C_BRANCH = 7'b0000110;
    localparam logic [6:0] C_LDUSE  = 7'b1100010;

    typedef struct {
        logic [6:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        to;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int          m_state = 0;
    int          m_wcnt  = 0;
    logic [15:0] m_sc    = 16'd0;
    logic [15:0] m_fc    = 16'd0;

    logic [6:0]  last_ctl;
    logic [1:0]  last_fa, last_fb;
    logic        last_to;
    logic [15:0] last_sc, last_fc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (ma_RegWEn && ma_rd == rs) return 2'b01;
        if (wb_RegWEn && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.ctl = C_NONE;
        e.fa  = 2'b00;
        e.fb  = 2'b00;
        e.to  = (m_state == 2);
        e.sc  = m_sc;
        e.fc  = m_fc;
        if (reset) return e;
        if (m_state == 2) begin
            e.ctl = C_FREEZE;
            return e;
        end
        e.fa = fwd_exp(id_rs1);
        e.fb = fwd_exp(id_rs2);
        if (ma_mem_access && !dmem_ready)
            e.ctl = C_FREEZE;
        else if (ex_branch_taken)
            e.ctl = C_BRANCH;
        else if (ex_RegWEn && ex_WBSel == 2'b00 && ex_rd != 5'd0 && (ex_rd == if_rs1 || ex_rd == if_rs2))
            e.ctl = C_LDUSE;
        return e;
    endfunction

    task automatic model_edge();
        exp_t e;
        if (reset) begin
            m_state = 0; m_wcnt = 0; m_sc = 16'd0; m_fc = 16'd0;
            return;
        end
        e = model_out();
        if (e.ctl[6] && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
        if (e.ctl == C_BRANCH && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
        case (m_state)
            0: if (ma_mem_access && !dmem_ready) begin m_state = 1; m_wcnt = 0; end
            1: begin
                if (dmem_ready || !ma_mem_access) m_state = 0;
                else if (m_wcnt == 255) m_state = 2;
                else m_wcnt++;
            end
            default: ;
        endcase
    endtask

    task automatic tick(input bit chk);
        exp_t e;
        if (chk) sb_q.push_back(model_out());
        @(negedge clk);
        last_ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_ma, flush_if_id, flush_id_ex, bubble_ma_wb};
        last_fa = fwd_a; last_fb = fwd_b; last_to = mem_timeout;
        last_sc = stall_count; last_fc = flush_count;
        if (chk) begin
            e = sb_q.pop_front();
            check_eq("sb_ctl", {25'd0, last_ctl}, {25'd0, e.ctl});
            check_eq("sb_fwd_a", {30'd0, last_fa}, {30'd0, e.fa});
            check_eq("sb_fwd_b", {30'd0, last_fb}, {30'd0, e.fb});
            check_eq("sb_timeout", {31'd0, last_to}, {31'd0, e.to});
            check_eq("sb_stall_count", {16'd0, last_sc}, {16'd0, e.sc});
            check_eq("sb_flush_count", {16'd0, last_fc}, {16'd0, e.fc});
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ma_rd = 0; wb_rd = 0; if_rs1 = 0; if_rs2 = 0;
        ex_RegWEn = 0; ma_RegWEn = 0; wb_RegWEn = 0; ma_mem_access = 0;
        ex_branch_taken = 0; dmem_ready = 0; ex_WBSel = 2'b01;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        check_eq("rst_ctl_zero", {25'd0, last_ctl}, 32'd0);
        check_eq("rst_fwd_zero", {28'd0, last_fa, last_fb}, 32'd0);
        reset = 1'b0;
    endtask

    int first_to;

    initial begin
        clear_in();
        reset = 1'b1;
        @(posedge clk); #1;
        do_reset();
        clear_in();
        tick(1);
        check_eq("post_rst_counts", {last_sc, last_fc}, 32'd0);

        ma_rd = 5; ma_RegWEn = 1; wb_rd = 5; wb_RegWEn = 1; id_rs1 = 5;
        tick(1);
        check_eq("fwd_ma_priority", {30'd0, last_fa}, 32'd1);
        ma_rd = 0;
        tick(1);
        check_eq("fwd_wb_when_ma_x0", {30'd0, last_fa}, 32'd2);
        id_rs2 = 5; id_rs1 = 0; wb_rd = 0; ma_rd = 0;
        tick(1);
        check_eq("fwd_x0_never", {28'd0, last_fa, last_fb}, 32'd0);

        do_reset();
        clear_in();
        ex_WBSel = 2'b00; ex_RegWEn = 1; ex_rd = 7; if_rs2 = 7;
        tick(1);
        check_eq("ld_use_ctl", {25'd0, last_ctl}, {25'd0, C_LDUSE});
        clear_in();
        tick(1);
        check_eq("ld_use_count", {16'd0, last_sc}, 32'd1);
        check_eq("ld_use_one_cycle", {25'd0, last_ctl}, 32'd0);
        ex_WBSel = 2'b00; ex_RegWEn = 1; ex_rd = 0; if_rs1 = 0;
        tick(1);
        check_eq("ld_use_x0_ignored", {25'd0, last_ctl}, 32'd0);

        do_reset();
        clear_in();
        ma_mem_access = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_eq("mem_wait_freeze", {25'd0, last_ctl}, {25'd0, C_FREEZE});
        end
        dmem_ready = 1;
        tick(1);
        check_eq("mem_wait_release", {25'd0, last_ctl}, 32'd0);
        clear_in();
        tick(1);
        check_eq("mem_wait_count", {16'd0, last_sc}, 32'd3);
        check_eq("mem_wait_no_to", {31'd0, last_to}, 32'd0);

        do_reset();
        clear_in();
        ex_branch_taken = 1; ex_WBSel = 2'b00; ex_RegWEn = 1; ex_rd = 7; if_rs1 = 7;
        tick(1);
        check_eq("branch_over_lduse", {25'd0, last_ctl}, {25'd0, C_BRANCH});
        clear_in();
        tick(1);
        check_eq("branch_flush_count", {16'd0, last_fc}, 32'd1);
        check_eq("branch_no_stall", {16'd0, last_sc}, 32'd0);

        ma_mem_access = 1; dmem_ready = 0;
        tick(1);
        dmem_ready = 1; ex_branch_taken = 1;
        tick(1);
        check_eq("ready_plus_branch", {25'd0, last_ctl}, {25'd0, C_BRANCH});
        clear_in();

        do_reset();
        clear_in();
        ma_mem_access = 1; dmem_ready = 0; ma_rd = 3; ma_RegWEn = 1; id_rs1 = 3;
        first_to = -1;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (first_to < 0 && last_to === 1'b1) first_to = i;
        end
        check_eq("timeout_latency", first_to, 32'd257);
        check_eq("timeout_ctl", {25'd0, last_ctl}, {25'd0, C_FREEZE});
        check_eq("timeout_fwd_zero", {30'd0, last_fa}, 32'd0);
        dmem_ready = 1; ma_mem_access = 0; ex_branch_taken = 1;
        for (int i = 0; i < 4; i++) tick(1);
        check_eq("timeout_sticky", {31'd0, last_to}, 32'd1);
        check_eq("timeout_no_flush", {25'd0, last_ctl}, {25'd0, C_FREEZE});
        do_reset();
        clear_in();
        tick(1);
        check_eq("timeout_cleared", {31'd0, last_to}, 32'd0);
        check_eq("timeout_rst_ctl", {25'd0, last_ctl}, 32'd0);

        do_reset();
        clear_in();
        ma_mem_access = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) tick(1);
        reset = 1'b1;
        tick(1);
        check_eq("midwait_rst_ctl", {25'd0, last_ctl}, 32'd0);
        reset = 1'b0;
        clear_in();
        tick(1);
        check_eq("midwait_after_ctl", {25'd0, last_ctl}, 32'd0);
        check_eq("midwait_after_cnt", {last_sc, last_fc}, 32'd0);
        check_eq("midwait_after_to", {31'd0, last_to}, 32'd0);

        ex_WBSel = 2'b00; ex_RegWEn = 1; ex_rd = 9; if_rs1 = 9;
        for (int i = 0; i < 65536; i++) tick(0);
        tick(1);
        check_eq("stall_saturate", {16'd0, last_sc}, 32'h0000FFFF);
        tick(1);
        check_eq("stall_no_wrap", {16'd0, last_sc}, 32'h0000FFFF);
        clear_in();
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
